// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the request legality helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StLwait  = 2'd2,
        StResp   = 2'd3
    } lsu_state_e;

    // Stores only support the signed codes; unsigned variants exist for loads only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        unique case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        unique case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a memory word and sign/zero-extends it
// according to the load width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        unique case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {24'b0, shifted[7:0]};
            F3_HU:   data_o = {16'b0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: validates one request at a time, drives a byte-enabled
// synchronous memory and returns aligned load data over a valid/ready response.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_AW = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [2:0]         req_funct3_i,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [31:0]        resp_rdata_o,
    output logic               resp_err_o,
    output logic [WORD_AW-1:0] mem_addr_o,
    output logic [3:0]         mem_be_o,
    output logic               mem_we_o,
    output logic               mem_re_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] load_data;

    logic        req_fire;
    logic        req_err;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_lanes;

    assign req_fire = req_valid_i & req_ready_o;

    always_comb begin
        req_err = ~funct3_legal(req_we_i, req_funct3_i)
                | misaligned(req_funct3_i, req_addr_i[1:0])
                | (|req_addr_i[ADDR_W-1:WORD_AW+2]);
        unique case (req_funct3_i[1:0])
            2'b00: begin
                req_be          = 4'b0001 << req_addr_i[1:0];
                req_wdata_lanes = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_be          = 4'b0011 << req_addr_i[1:0];
                req_wdata_lanes = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_be          = 4'b1111;
                req_wdata_lanes = req_wdata_i;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i   (mem_rdata_i),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    // Memory-side outputs are loaded at the accept edge so they are registered in ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= 32'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= 4'b0;
            mem_we_o     <= 1'b0;
            mem_re_o     <= 1'b0;
            mem_wdata_o  <= 32'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        addr_lo_q   <= req_addr_i[1:0];
                        req_ready_o <= 1'b0;
                        if (req_err) begin
                            state_q      <= StResp;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'b0;
                        end else begin
                            state_q     <= StAccess;
                            mem_addr_o  <= req_addr_i[WORD_AW+1:2];
                            mem_be_o    <= req_be;
                            mem_wdata_o <= req_wdata_lanes;
                            mem_we_o    <= req_we_i;
                            mem_re_o    <= ~req_we_i;
                        end
                    end
                end
                StAccess: begin
                    mem_we_o <= 1'b0;
                    mem_re_o <= 1'b0;
                    if (we_q) begin
                        state_q      <= StResp;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= 32'b0;
                    end else begin
                        state_q <= StLwait;
                    end
                end
                StLwait: begin
                    state_q      <= StResp;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= load_data;
                end
                StResp: begin
                    if (resp_ready_i) begin
                        state_q      <= StIdle;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= 32'b0;
                        req_ready_o  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus random traffic
// compared against a byte-addressed reference memory.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [10:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'b0;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [2048];
    logic [7:0]  ref_mem [8192];

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_we_o     (mem_we),
        .mem_re_o     (mem_re),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous-read, byte-enabled data memory.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall);
        bit              err;
        int              size;
        logic [3:0]      ebe;
        logic [31:0]     ewd;
        logic [31:0]     ersp;
        longint unsigned v;

        size = 1 << (f3 % 4);
        err  = we ? (f3 > 2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!err && (addr % size) != 0) err = 1;
        if (addr >= 32'd8192) err = 1;

        ebe  = '0;
        ewd  = '0;
        ersp = '0;
        if (!err) begin
            for (int i = 0; i < size; i++) ebe[(addr % 4) + i] = 1'b1;
            for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % size) +: 8];
            if (!we) begin
                v = 0;
                for (int i = 0; i < size; i++) v |= longint'(ref_mem[addr + i]) << (8 * i);
                if (f3 < 4 && v[8*size-1]) v |= ~64'd0 << (8 * size);
                ersp = v[31:0];
            end
        end

        resp_ready = (stall == 0);
        @(posedge clk); #1;
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (err) begin
            chk("err_no_we", mem_we, 1'b0);
            chk("err_no_re", mem_re, 1'b0);
        end else begin
            chk("acc_we", mem_we, we);
            chk("acc_re", mem_re, !we);
            chk("acc_addr", mem_addr, addr[12:2]);
            chk("acc_be", mem_be, ebe);
            if (we) chk("acc_wdata", mem_wdata, ewd);
            chk("acc_no_resp", resp_valid, 1'b0);
            chk("acc_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
            chk("strobe_pulse_we", mem_we, 1'b0);
            chk("strobe_pulse_re", mem_re, 1'b0);
            if (!we) begin
                chk("lwait_no_resp", resp_valid, 1'b0);
                @(posedge clk); #1;
            end
        end
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, ersp);

        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", resp_valid, 1'b1);
            chk("stall_rdata", resp_rdata, ersp);
            chk("stall_req_ready", req_ready, 1'b0);
            chk("stall_no_strobe", {mem_we, mem_re}, 2'b00);
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'd2;
            req_addr   = 32'h0;
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("resp_done", resp_valid, 1'b0);
        chk("back_idle", req_ready, 1'b1);
        chk("idle_no_strobe", {mem_we, mem_re}, 2'b00);

        if (we && !err) begin
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
        end
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        logic       rwe;
        logic [2:0] rf3;
        logic [31:0] raddr;

        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 2048; i++) mem[i] = 32'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'b0;

        #2 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'b0);
        chk("rst_mem_strobes", {mem_we, mem_re}, 2'b00);
        chk("rst_mem_be", mem_be, 4'b0);
        chk("rst_mem_addr", mem_addr, 11'b0);
        chk("rst_mem_wdata", mem_wdata, 32'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b1, 3'd0, 32'h13, 32'h123456A5, 0);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 0);
        do_req(1'b1, 3'd1, 32'h22, 32'hABCD8001, 0);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, 0);
        do_req(1'b0, 3'd5, 32'h22, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h06, 32'h0, 0);
        do_req(1'b0, 3'd1, 32'h05, 32'h0, 0);
        do_req(1'b0, 3'd3, 32'h00, 32'h0, 0);
        do_req(1'b1, 3'd0, 32'h2000, 32'hFF, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5);

        // Reset during a store's ACCESS cycle must drop the write.
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h40;
        req_wdata  = 32'h11111111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst_we", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_resp_valid", resp_valid, 1'b0);
        #2 rst = 1'b0;
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rf3 = legal_f3[$urandom_range(0, rwe ? 2 : 4)];
            raddr = ($urandom_range(0, 9) == 0) ? 32'h2000 + $urandom_range(0, 255)
                                                : 32'($urandom_range(0, 63));
            do_req(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
